sevenseg_scan_driver: RTL and testbench
=======================================

Name: sevenseg_scan_driver

Overview:
Multiplexed N-digit seven-segment display driver, the parametrised successor to the single-digit combinational decoder. Latches a packed hex value, scans digits time-multiplexed with a programmable refresh period, and inserts an anti-ghosting blank gap between digits. Updates are tear-free: new values take effect only at frame boundaries. Sits between the datapath and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; 1..8.
DIGIT_CYCLES, 50000, clock cycles per digit slot; must be >= 2.
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; 0 <= BLANK_CYCLES < DIGIT_CYCLES.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
value  input  4*NUM_DIGITS  packed hex nibbles; digit 0 = value[3:0] (rightmost)
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_in  input  NUM_DIGITS  per-digit force-blank, 1 = digit dark
load  input  1  capture value/dp_in/blank_in into pending register
seg  output  7  segments, active low (pull-down lights); seg[0]=a ... seg[6]=g
dp_n  output  1  decimal point, active low
an  output  NUM_DIGITS  digit enables, active low, one-hot-low when driving
frame_done  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: seg=7'h7F, dp_n=1, an=all 1, frame_done=0, digit index=0, slot counter=0, state=BLANK, display and pending registers=0, pending_valid=0.
- State machine per slot: BLANK (counter < BLANK_CYCLES, an all 1, seg=7'h7F, dp_n=1) -> DRIVE (remaining cycles; an[idx]=0, seg=decode(nibble idx), dp_n=~dp[idx]). If BLANK_CYCLES=0, BLANK is skipped.
- Slot counter counts 0..DIGIT_CYCLES-1; on terminal count: counter->0, idx increments; at idx=NUM_DIGITS-1 wraps to 0 and frame_done=1 for that one cycle.
- All outputs registered; pin changes lag state by exactly one cycle. DRIVE lasts exactly DIGIT_CYCLES-BLANK_CYCLES cycles per slot.
- load: captures into pending, sets pending_valid. Repeated loads before a frame boundary overwrite pending (last wins).
- Frame boundary (wrap cycle): if pending_valid, display <= pending, pending_valid <= 0. Load on the same cycle as wrap: incoming value goes straight to display, pending_valid stays 0.
- blank_in[i]=1: digit i still takes its slot, but an stays all 1 for the whole slot.
- Decode: standard hex 0-F, active low: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110.
- rst mid-slot: all state returns to reset values on the next edge; pending load is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN: when defined, digits above the most significant non-zero nibble of the displayed value are blanked (treated as blank_in=1) unless their dp bit is set. Digit 0 is never suppressed, so all-zero shows a single "0". When undefined, all digits display, including leading zeros.

Decomposition:
- Package sevenseg_pkg: localparam segment patterns SEG_HEX[0:15] (active low), SEG_OFF=7'h7F, scan state enum {BLANK, DRIVE}.
- Sub-module sevenseg_hex_decode: combinational 4-bit nibble -> 7-bit active-low pattern, instantiated once on the muxed nibble.

Test Plan:
- Reset, NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2: hold rst 3 cycles -> an=4'b1111, seg=7'h7F, dp_n=1, frame_done=0 throughout.
- load value=16'h1F80 -> after the next frame boundary, slots show digit0 seg=7'b1000000 an=4'b1110, digit1 7'b0000000, digit2 7'b0001110, digit3 7'b1111001. Each an low for exactly 6 cycles after 2 dark cycles.
- Scan timing -> frame_done pulses once every 32 cycles, high for exactly 1 cycle, coincident with idx wrap 3->0.
- load 16'h1111 mid-frame, then 16'h2222 before the wrap -> current frame unchanged, next frame shows 2222 only. Load on the exact wrap cycle -> applies immediately.
- blank_in=4'b0100, dp_in=4'b0001 -> an[2] never low; dp_n=0 only during digit 0 DRIVE.
- rst asserted mid-DRIVE of digit 2 with pending load -> next cycle outputs at reset values; after release, display=0, scan restarts at digit 0. With LEADING_ZERO_BLANK_EN, value 16'h0042 -> digits 3,2 dark, digits 1,0 show 4,2.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
//   Shared constants and types for the multiplexed seven-segment driver.
//   - SEG_HEX : active-low segment patterns for hex digits 0..F,
//               bit order {g,f,e,d,c,b,a} (seg[0] = a).
//   - SEG_OFF : all segments dark.
//   - scan_state_e : per-slot scan phase (BLANK gap, then DRIVE).
// -----------------------------------------------------------------------------
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// -----------------------------------------------------------------------------
// sevenseg_hex_decode
//   Purely combinational hex nibble to active-low seven-segment decoder.
//   Ports:
//     nibble_i [3:0] : hex digit to display
//     seg_o    [6:0] : active-low segments, seg_o[0] = a ... seg_o[6] = g
// -----------------------------------------------------------------------------
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed N-digit seven-segment driver. A packed hex value is
//   captured into a pending register and promoted to the display register
//   only at a frame boundary, so a frame never shows a mix of old and new
//   digits. Each digit owns a slot of DIGIT_CYCLES clocks; the first
//   BLANK_CYCLES of every slot keep all anodes off to stop ghosting while
//   the segment lines settle to the next digit.
//
//   Parameters:
//     NUM_DIGITS   : digits scanned, 1..8
//     DIGIT_CYCLES : clocks per digit slot, >= 2
//     BLANK_CYCLES : dark clocks at slot start, 0 .. DIGIT_CYCLES-1
//
//   Ports:
//     clk        : system clock
//     rst        : synchronous, active-high reset
//     value      : packed hex nibbles, digit 0 = value[3:0] (rightmost)
//     dp_in      : per-digit decimal point request, 1 = lit
//     blank_in   : per-digit force-blank, 1 = digit dark for its slot
//     load       : capture value/dp_in/blank_in into the pending register
//     seg        : active-low segments, seg[0] = a ... seg[6] = g
//     dp_n       : active-low decimal point
//     an         : active-low digit enables, one-hot-low while driving
//     frame_done : one-cycle pulse as the last digit slot ends
//
//   Optional build macro:
//     LEADING_ZERO_BLANK_EN : when defined, digits above the most significant
//       non-zero nibble are darkened unless their decimal point is set.
//       Digit 0 is never suppressed.
//
//   All pins are registered, so pin changes trail the internal scan state by
//   exactly one clock.
// -----------------------------------------------------------------------------
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // Scan position
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_end;
  logic             frame_end;
  scan_state_e      state;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  assign cnt_d = slot_end ? '0 : cnt_q + 1'b1;

  always_comb begin
    idx_d = idx_q;
    if (frame_end) begin
      idx_d = '0;
    end else if (slot_end) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // The phase is a pure function of the slot counter. With no blank gap
  // the comparison would be constant-false, so that case is split out.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank_gap
      assign state = (cnt_q < CNT_W'(BLANK_CYCLES)) ? BLANK : DRIVE;
    end else begin : g_no_blank_gap
      assign state = DRIVE;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pending / display registers (tear-free update at the frame boundary)
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q,    pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    pend_valid_q, pend_valid_d;

  logic [4*NUM_DIGITS-1:0] disp_value_q, disp_value_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q,    disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;

  always_comb begin
    // NOTE: every signal this block drives gets a default first; a path that
    // left one unassigned would infer a latch.
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;

    // Later loads simply overwrite earlier ones: last load before the
    // boundary wins.
    if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      pend_valid_d = 1'b1;
    end

    // A load coinciding with the wrap bypasses pending and goes straight to
    // the display, so it is never left waiting a whole extra frame.
    if (frame_end) begin
      if (load) begin
        disp_value_d = value;
        disp_dp_d    = dp_in;
        disp_blank_d = blank_in;
      end else if (pend_valid_q) begin
        disp_value_d = pend_value_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
      end
      pend_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Effective per-digit blanking
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] eff_blank;

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_seen;

  // Walk from the top digit down; until a non-zero nibble has been seen the
  // digit is a leading zero. A lit decimal point keeps its digit visible.
  // Digit 0 is excluded so an all-zero value still shows one "0".
  always_comb begin
    eff_blank = disp_blank_q;
    lz_seen   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_value_q[4*i +: 4] != 4'h0) begin
        lz_seen = 1'b1;
      end
      if (!lz_seen && !disp_dp_q[i]) begin
        eff_blank[i] = 1'b1;
      end
    end
  end
`else
  assign eff_blank = disp_blank_q;
`endif

  // ---------------------------------------------------------------------------
  // Current-digit select and decode
  // ---------------------------------------------------------------------------
  logic [3:0] cur_nibble;
  logic       cur_dp;
  logic       cur_blank;
  logic [6:0] dec_seg;
  logic       drive_on;

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nibble = disp_value_q[4*i +: 4];
        cur_dp     = disp_dp_q[i];
        cur_blank  = eff_blank[i];
      end
    end
  end

  sevenseg_hex_decode u_decode (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  // A force-blanked digit still consumes its slot; it just never lights.
  assign drive_on = (state == DRIVE) && !cur_blank;

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [6:0]            seg_q,        seg_d;
  logic                  dp_n_q,       dp_n_d;
  logic [NUM_DIGITS-1:0] an_q,         an_d;
  logic                  frame_done_q, frame_done_d;

  always_comb begin
    seg_d        = drive_on ? dec_seg : SEG_OFF;
    dp_n_d       = drive_on ? ~cur_dp : 1'b1;
    frame_done_d = frame_end;
    an_d         = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = ~(drive_on && (idx_q == IDX_W'(i)));
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples the pre-edge
  // value of every other; blocking ones would make results depend on
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: display and pending contents are plain flops, not a memory
      // array, so they are reset too; the first frame after reset then shows
      // a defined all-zero picture and any half-done load is discarded.
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= SEG_OFF;
      dp_n_q       <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Self-checking bench for sevenseg_scan_driver with NUM_DIGITS=4,
//   DIGIT_CYCLES=8, BLANK_CYCLES=2. A reference model tracks an absolute
//   scan position and the displayed/pending values and predicts every pin
//   each cycle; a vector table checks decoded digits per slot, and
//   hand-written sequences cover load timing, blanking and reset.
//   Honours LEADING_ZERO_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

  localparam int N  = 4;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int F  = N * DC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .NUM_DIGITS   (N),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_done (frame_done)
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int          pos = 0;        // scan position (clocks since reset release)
  logic [15:0] m_val = '0, p_val = '0;
  logic [3:0]  m_dp = '0, p_dp = '0, m_blank = '0, p_blank = '0;
  logic        p_valid = 1'b0;

  // Segment pattern from the list of lit segments of each glyph.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    string      lit;
    logic [6:0] s;
    case (n)
      4'h0: lit = "abcdef";   4'h1: lit = "bc";
      4'h2: lit = "abdeg";    4'h3: lit = "abcdg";
      4'h4: lit = "bcfg";     4'h5: lit = "acdfg";
      4'h6: lit = "acdefg";   4'h7: lit = "abc";
      4'h8: lit = "abcdefg";  4'h9: lit = "abcdfg";
      4'hA: lit = "abcefg";   4'hB: lit = "cdefg";
      4'hC: lit = "adef";     4'hD: lit = "bcdeg";
      4'hE: lit = "adefg";    default: lit = "aefg";
    endcase
    s = 7'h7F;
    for (int k = 0; k < lit.len(); k++) s[int'(lit[k]) - 97] = 1'b0;
    return s;
  endfunction

  function automatic bit digit_dark(input int d);
    bit dark;
`ifdef LEADING_ZERO_BLANK_EN
    int msd;
`endif
    dark = m_blank[d];
`ifdef LEADING_ZERO_BLANK_EN
    msd = 0;
    for (int j = 0; j < N; j++) if (m_val[4*j +: 4] != 4'h0) msd = j;
    if (d > msd && !m_dp[d]) dark = 1'b1;
`endif
    return dark;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t pos=%0d)", name, act, exp, $time, pos);
    end
  endtask

  // One clock: drive inputs, clock, predict pins from the pre-edge model,
  // advance the model, compare.
  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dpn, e_fd, care;
    int         dig, ph;
    bit         boundary;
    rst = r; load = ld; value = v; dp_in = d; blank_in = b;
    @(posedge clk);
    #1;
    e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fd = 1'b0; care = 1'b1;
    if (!r) begin
      dig  = (pos / DC) % N;
      ph   = pos % DC;
      e_fd = (pos % F == F - 1);
      if (ph >= BC) begin
        if (digit_dark(dig)) begin
          care = 1'b0;
        end else begin
          e_an  = ~(4'b0001 << dig);
          e_seg = seg_of(m_val[4*dig +: 4]);
          e_dpn = ~m_dp[dig];
        end
      end
    end
    if (r) begin
      pos = 0; m_val = '0; m_dp = '0; m_blank = '0;
      p_val = '0; p_dp = '0; p_blank = '0; p_valid = 1'b0;
    end else begin
      boundary = (pos % F == F - 1);
      if (ld && boundary) begin
        m_val = v; m_dp = d; m_blank = b; p_valid = 1'b0;
      end else begin
        if (boundary && p_valid) begin
          m_val = p_val; m_dp = p_dp; m_blank = p_blank; p_valid = 1'b0;
        end
        if (ld) begin
          p_val = v; p_dp = d; p_blank = b; p_valid = 1'b1;
        end
      end
      pos++;
    end
    check("an", an, e_an);
    check("frame_done", frame_done, e_fd);
    if (care) begin
      check("seg", seg, e_seg);
      check("dp_n", dp_n, e_dpn);
    end
  endtask

  task automatic idle();
    logic [31:0] rv;
    rv = $urandom;
    step(1'b0, 1'b0, rv[15:0], rv[19:16], rv[23:20]);
  endtask

  task automatic advance_to(input int tgt);
    for (int k = 0; k < F; k++) begin
      if (pos % F == tgt) break;
      idle();
    end
  endtask

  // Per-frame observations.
  logic [6:0] obs_seg [N];
  logic       obs_dpn [N];
  int         low_cnt [N];
  int         dp_low, dp_bad, fd_cnt, fd_at;

  task automatic capture_frame();
    logic [3:0] sel;
    advance_to(0);
    for (int d = 0; d < N; d++) begin
      obs_seg[d] = 7'h7F; obs_dpn[d] = 1'b1; low_cnt[d] = 0;
    end
    dp_low = 0; dp_bad = 0; fd_cnt = 0; fd_at = -1;
    for (int k = 0; k < F; k++) begin
      idle();
      for (int d = 0; d < N; d++) begin
        sel = ~(4'b0001 << d);
        if (an == sel) begin
          low_cnt[d]++;
          obs_seg[d] = seg;
          obs_dpn[d] = dp_n;
        end
      end
      if (dp_n == 1'b0) begin
        dp_low++;
        if (an != 4'b1110) dp_bad++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_at = k;
      end
    end
  endtask

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0][6:0] seg;   // expected pattern, index = digit
    logic [3:0]      dpn;   // expected dp_n, index = digit
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [31:0] rv;
    logic        r, ld;

    vecs[0] = '{value: 16'h1F80, dp: 4'b0000,
                seg: {7'b1111001, 7'b0001110, 7'b0000000, 7'b1000000}, dpn: 4'b1111};
    vecs[1] = '{value: 16'h9A5C, dp: 4'b0001,
                seg: {7'b0010000, 7'b0001000, 7'b0010010, 7'b1000110}, dpn: 4'b1110};
    vecs[2] = '{value: 16'hB6D3, dp: 4'b1010,
                seg: {7'b0000011, 7'b0000010, 7'b0100001, 7'b0110000}, dpn: 4'b0101};
    vecs[3] = '{value: 16'h7E42, dp: 4'b0000,
                seg: {7'b1111000, 7'b0000110, 7'b0011001, 7'b0100100}, dpn: 4'b1111};

    // Reset held for three cycles: pins at reset values throughout.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'hFFFF, 4'hF, 4'h0);

    // Table: every hex glyph, dp patterns, slot timing and frame pulse.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, vecs[i].value, vecs[i].dp, 4'b0000);
      capture_frame();
      for (int d = 0; d < N; d++) begin
        check("tbl_seg", obs_seg[d], vecs[i].seg[d]);
        check("tbl_dpn", obs_dpn[d], vecs[i].dpn[d]);
        check("tbl_drive_len", low_cnt[d], DC - BC);
      end
      check("tbl_fd_count", fd_cnt, 1);
      check("tbl_fd_pos", fd_at, F - 1);
    end

    // Two loads inside one frame: last one wins at the next boundary.
    advance_to(5);
    step(1'b0, 1'b1, 16'h1111, 4'b0000, 4'b0000);
    advance_to(20);
    step(1'b0, 1'b1, 16'h2222, 4'b0000, 4'b0000);
    capture_frame();
    for (int d = 0; d < N; d++) check("last_wins_seg", obs_seg[d], 7'b0100100);

    // Load on the exact wrap cycle applies to the very next frame.
    advance_to(F - 1);
    step(1'b0, 1'b1, 16'h3C5A, 4'b0000, 4'b0000);
    capture_frame();
    check("wrap_load_d0", obs_seg[0], 7'b0001000);
    check("wrap_load_d1", obs_seg[1], 7'b0010010);
    check("wrap_load_d2", obs_seg[2], 7'b1000110);
    check("wrap_load_d3", obs_seg[3], 7'b0110000);

    // Force-blank digit 2, decimal point on digit 0 only.
    step(1'b0, 1'b1, 16'h5678, 4'b0001, 4'b0100);
    capture_frame();
    check("blank_an2_low", low_cnt[2], 0);
    check("blank_an0_low", low_cnt[0], DC - BC);
    check("dp_low_cycles", dp_low, DC - BC);
    check("dp_outside_d0", dp_bad, 0);

    // Reset mid-DRIVE of digit 2 with a load still pending.
    advance_to(3);
    step(1'b0, 1'b1, 16'hABCD, 4'b0000, 4'b0000);
    advance_to(2 * DC + 4);
    step(1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    capture_frame();
    check("post_rst_d0", obs_seg[0], 7'b1000000);
`ifdef LEADING_ZERO_BLANK_EN
    check("post_rst_lz_d3", low_cnt[3], 0);
`else
    check("post_rst_d3", obs_seg[3], 7'b1000000);
`endif

    // Leading zeros on 0x0042.
    step(1'b0, 1'b1, 16'h0042, 4'b0000, 4'b0000);
    capture_frame();
    check("lz_d1", obs_seg[1], 7'b0011001);
    check("lz_d0", obs_seg[0], 7'b0100100);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d3_dark", low_cnt[3], 0);
    check("lz_d2_dark", low_cnt[2], 0);
`else
    check("lz_d3_zero", obs_seg[3], 7'b1000000);
    check("lz_d2_zero", obs_seg[2], 7'b1000000);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      r  = ($urandom_range(0, 399) == 0);
      ld = ($urandom_range(0, 15) == 0);
      rv = $urandom;
      step(r, ld, rv[15:0], rv[19:16], ($urandom_range(0, 3) == 0) ? rv[23:20] : 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
